// File: rtl/arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM state encoding
// and the bit-counter width helper.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter must reach WIDTH-1; a 1-bit operand still needs a 1-bit counter.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// Combinational 1-bit full-subtractor cell: diff = a - b - bin, with borrow-out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one full-subtractor cell reused
// for WIDTH cycles behind a start/busy/done handshake.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  state_t           state_q,  state_d;
  logic [WIDTH-1:0] a_sh_q,   a_sh_d;
  logic [WIDTH-1:0] b_sh_q,   b_sh_d;
  logic [WIDTH-1:0] res_q,    res_d;
  logic [WIDTH-1:0] diff_q,   diff_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic             bor_q,    bor_d;
  logic             borrow_q, borrow_d;

  logic             cell_d;
  logic             cell_bout;
  logic [WIDTH-1:0] res_shift;

  full_subtractor u_cell (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .bin  (bor_q),
    .diff (cell_d),
    .bout (cell_bout)
  );

  // New result bit enters at the MSB; written this way so WIDTH==1 needs no special case.
  assign res_shift = WIDTH'({cell_d, res_q} >> 1);

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    bor_d    = bor_q;
    borrow_d = borrow_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_sh_d  = a;
          b_sh_d  = b;
          bor_d   = 1'b0;
          cnt_d   = '0;
          res_d   = '0;
        end
      end
      RUN: begin
        res_d  = res_shift;
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        bor_d  = cell_bout;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          diff_d   = res_shift;
          borrow_d = cell_bout;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      bor_q    <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      bor_q    <= bor_d;
      borrow_q <= borrow_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=8 and WIDTH=1.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start8, start1;
  logic [7:0] a8, b8, diff8;
  logic [0:0] a1, b1, diff1;
  logic       busy8, done8, borrow8;
  logic       busy1, done1, borrow1;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .diff(diff1), .borrow(borrow1)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       bo;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  // Called at a negedge with dut8 idle; returns at the negedge of the done cycle.
  task automatic op8(input logic [7:0] av, input logic [7:0] bv, output int lat,
                     output logic [7:0] d, output logic bo, output logic busy_ok);
    start8 = 1'b1; a8 = av; b8 = bv;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    lat = 1; busy_ok = 1'b1;
    while (!done8 && lat < 40) begin
      if (!busy8) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (!busy8) busy_ok = 1'b0;
    d = diff8; bo = borrow8;
  endtask

  task automatic op1(input logic [0:0] av, input logic [0:0] bv, output int lat,
                     output logic [0:0] d, output logic bo);
    start1 = 1'b1; a1 = av; b1 = bv;
    @(negedge clk);
    start1 = 1'b0; a1 = 1'($urandom); b1 = 1'($urandom);
    lat = 1;
    while (!done1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    d = diff1; bo = borrow1;
  endtask

  initial begin
    int         lat, pulses, bad;
    logic [7:0] d8, ea, eb, ed;
    logic [0:0] d1, ra, rb;
    logic       bo, bok, ebo;
    logic [7:0] ops_a [0:63];
    logic [7:0] ops_b [0:63];

    tbl[0] = '{8'h5A, 8'h23, 8'h37, 1'b0};
    tbl[1] = '{8'h00, 8'h01, 8'hFF, 1'b1};
    tbl[2] = '{8'hFF, 8'hFF, 8'h00, 1'b0};
    tbl[3] = '{8'h80, 8'h7F, 8'h01, 1'b0};
    tbl[4] = '{8'h7F, 8'h80, 8'hFF, 1'b1};
    tbl[5] = '{8'hC3, 8'h00, 8'hC3, 1'b0};

    rst_n = 1'b0; start8 = 1'b0; start1 = 1'b0;
    a8 = '0; b8 = '0; a1 = '0; b1 = '0;
    repeat (3) @(negedge clk);
    check("reset8", {busy8, done8, borrow8, diff8}, 32'h0);
    check("reset1", {busy1, done1, borrow1, diff1}, 32'h0);

    // First op starts at the first post-reset edge.
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      op8(tbl[i].a, tbl[i].b, lat, d8, bo, bok);
      $display("vec %0d: a=%02h b=%02h -> diff=%02h borrow=%0d lat=%0d", i, tbl[i].a, tbl[i].b, d8, bo, lat);
      check($sformatf("lat[%0d]", i), lat, 9);
      check($sformatf("diff[%0d]", i), d8, tbl[i].d);
      check($sformatf("borrow[%0d]", i), bo, tbl[i].bo);
      check($sformatf("busy_run[%0d]", i), bok, 1);
      @(negedge clk);
      check($sformatf("after_done[%0d]", i), {busy8, done8}, 0);
    end

    // Start while busy is ignored.
    start8 = 1'b1; a8 = 8'h10; b8 = 8'h01;
    @(negedge clk); start8 = 1'b0;
    @(negedge clk);
    @(negedge clk); start8 = 1'b1; a8 = 8'h00; b8 = 8'h00;
    @(negedge clk); start8 = 1'b0;
    pulses = 0; d8 = 8'hXX; bo = 1'bx;
    for (int c = 4; c <= 25; c++) begin
      if (done8) begin pulses++; d8 = diff8; bo = borrow8; end
      @(negedge clk);
    end
    $display("busy-start: pulses=%0d diff=%02h borrow=%0d", pulses, d8, bo);
    check("ignored_pulses", pulses, 1);
    check("ignored_diff", d8, 8'h0F);
    check("ignored_borrow", bo, 1'b0);

    // Reset mid-operation, with start asserted alongside reset.
    start8 = 1'b1; a8 = 8'h03; b8 = 8'h05;
    @(negedge clk); start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0; start8 = 1'b1;
    @(negedge clk);
    check("midreset_outs", {busy8, done8, borrow8, diff8}, 32'h0);
    rst_n = 1'b1; start8 = 1'b0;
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8 || busy8) bad++;
    end
    check("no_done_after_abort", bad, 0);
    op8(8'h03, 8'h05, lat, d8, bo, bok);
    $display("post-reset op: diff=%02h borrow=%0d lat=%0d", d8, bo, lat);
    check("postreset_lat", lat, 9);
    check("postreset_result", {bo, d8}, {1'b1, 8'hFE});
    @(negedge clk);

    // Back-to-back with start held: accepts at cycles 0,10,20,..., done at +9.
    start8 = 1'b1;
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      ops_a[c] = 8'($urandom); ops_b[c] = 8'($urandom);
      a8 = ops_a[c]; b8 = ops_b[c];
      @(negedge clk);
      if (done8 !== ((c + 1) % 10 == 9)) begin
        bad++;
        $display("FAIL b2b_done_timing cycle %0d: done=%0d", c + 1, done8);
      end
      if ((c + 1) % 10 == 9) begin
        ea = ops_a[c + 1 - 9]; eb = ops_b[c + 1 - 9];
        ed = 8'(int'(ea) - int'(eb));
        $display("b2b op @%0d: a=%02h b=%02h -> diff=%02h borrow=%0d", c - 8, ea, eb, diff8, borrow8);
        check("b2b_result", {borrow8, diff8}, {ea < eb, ed});
      end
    end
    start8 = 1'b0;
    check("b2b_timing", bad, 0);
    repeat (12) @(negedge clk);

    // Random sweep, WIDTH=8 then WIDTH=1, against plain integer subtraction.
    for (int i = 0; i < 1000; i++) begin
      ea = 8'($urandom); eb = 8'($urandom_range(0, 255));
      op8(ea, eb, lat, d8, bo, bok);
      ed = 8'(int'(ea) - int'(eb)); ebo = (ea < eb);
      $display("rand8 %0d: a=%02h b=%02h -> %0d:%02h", i, ea, eb, bo, d8);
      check("rand8", {lat[7:0], bo, d8}, {8'd9, ebo, ed});
      @(negedge clk);
    end
    for (int i = 0; i < 1000; i++) begin
      ra = 1'($urandom); rb = 1'($urandom);
      op1(ra, rb, lat, d1, bo);
      $display("rand1 %0d: a=%0d b=%0d -> %0d:%0d", i, ra, rb, bo, d1);
      check("rand1", {lat[7:0], bo, d1}, {8'd2, ra < rb, 1'(int'(ra) - int'(rb))});
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
